// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: signal bundle between the screen/flow sequencer and its neighbours.
//   pix_x, pix_y     scan position from vga_ctrl
//   key_any          raw OR of direction keys (asynchronous)
//   game_over/_won   end-of-game levels from game_logic
//   score            live tail count from game_logic
//   start/game/end_pix  RGB565 streams from the three renderers
//   pix_data         selected RGB565 stream to vga_ctrl
//   game_rst         active-high reset to game_logic
//   page             00=START 01=ARM 10=PLAY 11=END
//   won, score_hold  result of the last finished game
// The slave modport is the sequencer's view; master is the environment's view.
interface game_flow_ctrl_if #(
  parameter int unsigned TAIL_W = 8
);
  logic [9:0]        pix_x;
  logic [9:0]        pix_y;
  logic              key_any;
  logic              game_over;
  logic              game_won;
  logic [TAIL_W-1:0] score;
  logic [15:0]       start_pix;
  logic [15:0]       game_pix;
  logic [15:0]       end_pix;
  logic [15:0]       pix_data;
  logic              game_rst;
  logic [1:0]        page;
  logic              won;
  logic [TAIL_W-1:0] score_hold;

  modport master (
    output pix_x, pix_y, key_any, game_over, game_won, score, start_pix, game_pix, end_pix,
    input  pix_data, game_rst, page, won, score_hold
  );

  modport slave (
    input  pix_x, pix_y, key_any, game_over, game_won, score, start_pix, game_pix, end_pix,
    output pix_data, game_rst, page, won, score_hold
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: screen/flow sequencer for the snake game.
// Walks START -> ARM -> PLAY -> END -> START, changing page only on the last active pixel
// of a frame, owns the game_logic reset, muxes the renderer pixel streams and freezes the
// final score/result for the end page.
// Ports:
//   vga_clk    pixel clock, all state on its rising edge
//   sys_rst_n  synchronous active-low reset
//   bus        game_flow_ctrl_if.slave (scan position, key, game status, pixel streams in;
//              pix_data, game_rst, page, won, score_hold out)
module game_flow_ctrl #(
  parameter logic [9:0]  H_LAST         = 10'd639,
  parameter logic [9:0]  V_LAST         = 10'd479,
  parameter int unsigned TAIL_W         = 8,
  parameter int unsigned ARM_FRAMES     = 2,
  parameter int unsigned END_FRAMES     = 600,
  parameter int unsigned END_MIN_FRAMES = 60
) (
  input logic             vga_clk,
  input logic             sys_rst_n,
  game_flow_ctrl_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(END_FRAMES + 1);
  localparam logic [CntW-1:0] ArmLast = CntW'(ARM_FRAMES - 1);
  localparam logic [CntW-1:0] EndLast = CntW'(END_FRAMES - 1);
  localparam logic [CntW-1:0] EndMax  = CntW'(END_FRAMES);
  localparam logic [CntW-1:0] EndMin  = CntW'(END_MIN_FRAMES);

  // Encoding doubles as the page output.
  typedef enum logic [1:0] {
    StStart = 2'b00,
    StArm   = 2'b01,
    StPlay  = 2'b10,
    StEnd   = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              start_pend_q, start_pend_d;
  logic              over_pend_q, over_pend_d;
  logic              won_next_q, won_next_d;
  logic              won_q, won_d;
  logic [TAIL_W-1:0] score_hold_q, score_hold_d;
  logic [15:0]       pix_q, pix_d;
  // [0],[1] synchronize key_any; [2] is the edge-detect history.
  logic [2:0]        key_sync_q, key_sync_d;
  // Counts the first three post-reset samples. Until the sync chain holds only real
  // samples, a key held through reset would look like a fresh press.
  logic [1:0]        fill_q, fill_d;

  logic frame_tick;
  logic key_pulse;

  assign frame_tick = (bus.pix_x == H_LAST) && (bus.pix_y == V_LAST);
  assign key_pulse  = key_sync_q[1] & ~key_sync_q[2] & (fill_q == 2'd3);

  always_comb begin
    key_sync_d = {key_sync_q[1:0], bus.key_any};
    fill_d     = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_pend_d = start_pend_q;
    over_pend_d  = over_pend_q;
    won_next_d   = won_next_q;
    won_d        = won_q;
    score_hold_d = score_hold_q;

    // Every frame_tick consumes or discards a pending start request.
    if (frame_tick) begin
      start_pend_d = 1'b0;
    end
    if (key_pulse && (state_q == StStart || state_q == StEnd)) begin
      start_pend_d = 1'b1;
    end

    unique case (state_q)
      StStart: begin
        if (frame_tick && start_pend_q) begin
          state_d = StArm;
          cnt_d   = '0;
        end
      end
      StArm: begin
        if (frame_tick) begin
          if (cnt_q == ArmLast) begin
            state_d = StPlay;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StPlay: begin
        if (bus.game_over || bus.game_won) begin
          over_pend_d = 1'b1;
          won_next_d  = won_next_q | bus.game_won;
        end
        if (frame_tick && over_pend_q) begin
          state_d      = StEnd;
          cnt_d        = '0;
          score_hold_d = bus.score;
          won_d        = won_next_q;
          over_pend_d  = 1'b0;
          won_next_d   = 1'b0;
        end
      end
      StEnd: begin
        if (frame_tick) begin
          if (cnt_q == EndLast || (start_pend_q && cnt_q >= EndMin)) begin
            state_d = StStart;
            cnt_d   = '0;
          end else if (cnt_q < EndMax) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StStart;
      end
    endcase

    if (state_d != state_q) begin
      start_pend_d = 1'b0;
    end
  end

  // Mux on the pre-edge state so a new page starts on a clean frame.
  always_comb begin
    pix_d = '0;
    unique case (state_q)
      StStart, StArm: pix_d = bus.start_pix;
      StPlay:         pix_d = bus.game_pix;
      StEnd:          pix_d = bus.end_pix;
      default:        pix_d = '0;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_q      <= StStart;
      cnt_q        <= '0;
      start_pend_q <= 1'b0;
      over_pend_q  <= 1'b0;
      won_next_q   <= 1'b0;
      won_q        <= 1'b0;
      score_hold_q <= '0;
      pix_q        <= '0;
      key_sync_q   <= '0;
      fill_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_pend_q <= start_pend_d;
      over_pend_q  <= over_pend_d;
      won_next_q   <= won_next_d;
      won_q        <= won_d;
      score_hold_q <= score_hold_d;
      pix_q        <= pix_d;
      key_sync_q   <= key_sync_d;
      fill_q       <= fill_d;
    end
  end

  // game_rst also asserts combinationally while reset is being applied.
  assign bus.game_rst   = ~sys_rst_n | (state_q == StStart) | (state_q == StArm);
  assign bus.page       = state_q;
  assign bus.pix_data   = pix_q;
  assign bus.won        = won_q;
  assign bus.score_hold = score_hold_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed-plus-random bench for game_flow_ctrl. Frames are shortened
// to 12..20 pixels; the last pixel of each frame sits at (639,479). A frame-level
// reference model predicts page, result and pixel routing every cycle.
module tb_game_flow_ctrl;
  localparam logic [9:0] HL      = 10'd639;
  localparam logic [9:0] VL      = 10'd479;
  localparam int         ARM_F   = 2;
  localparam int         END_F   = 600;
  localparam int         END_MIN = 60;

  logic vga_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  game_flow_ctrl_if #(.TAIL_W(8)) bus ();

  game_flow_ctrl #(
    .H_LAST        (HL),
    .V_LAST        (VL),
    .TAIL_W        (8),
    .ARM_FRAMES    (ARM_F),
    .END_FRAMES    (END_F),
    .END_MIN_FRAMES(END_MIN)
  ) dut (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: page, frames spent in it, pending requests and the latched result.
  logic [1:0]  m_page;
  int          m_ticks;
  bit          m_pend, m_over, m_won_next, m_won;
  logic [7:0]  m_hold;
  logic [15:0] exp_pix;
  int          ecount     = 0;
  int          press_edge = -100;
  bit          key_last, key_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic [9:0] px, input logic [9:0] py);
    logic [1:0] old_page;
    bit         tick, rst;
    bus.pix_x     = px;
    bus.pix_y     = py;
    bus.start_pix = 16'($urandom);
    bus.game_pix  = 16'($urandom);
    bus.end_pix   = 16'($urandom);
    #1;
    if (!sys_rst_n) chk("game_rst_during_rst", 32'(bus.game_rst), 32'd1);
    tick = (px == HL) && (py == VL);
    rst  = !sys_rst_n;
    @(posedge vga_clk);
    ecount++;
    if (rst) begin
      exp_pix    = '0;
      m_page     = 2'd0;
      m_ticks    = 0;
      m_pend     = 1'b0;
      m_over     = 1'b0;
      m_won_next = 1'b0;
      m_won      = 1'b0;
      m_hold     = '0;
      key_valid  = 1'b0;
      press_edge = -100;
    end else begin
      case (m_page)
        2'd2:    exp_pix = bus.game_pix;
        2'd3:    exp_pix = bus.end_pix;
        default: exp_pix = bus.start_pix;
      endcase
      old_page = m_page;
      if (tick) begin
        case (m_page)
          2'd0: if (m_pend) begin m_page = 2'd1; m_ticks = 0; end
          2'd1: begin
            m_ticks++;
            if (m_ticks == ARM_F) begin m_page = 2'd2; m_ticks = 0; end
          end
          2'd2: if (m_over) begin
            m_page     = 2'd3;
            m_ticks    = 0;
            m_hold     = bus.score;
            m_won      = m_won_next;
            m_over     = 1'b0;
            m_won_next = 1'b0;
          end
          default: begin
            if (m_ticks + 1 == END_F || (m_pend && m_ticks >= END_MIN)) begin
              m_page  = 2'd0;
              m_ticks = 0;
            end else if (m_ticks < END_F) begin
              m_ticks++;
            end
          end
        endcase
        m_pend = 1'b0;
      end
      if (old_page == 2'd2 && m_page == 2'd2 && (bus.game_over || bus.game_won)) begin
        m_over     = 1'b1;
        m_won_next = m_won_next | bus.game_won;
      end
      // A sampled rising edge becomes a start request two clocks later.
      if (press_edge + 2 == ecount && (old_page == 2'd0 || old_page == 2'd3) &&
          m_page == old_page) m_pend = 1'b1;
      if (key_valid && !key_last && bus.key_any) press_edge = ecount;
      key_last  = bus.key_any;
      key_valid = 1'b1;
    end
    #1;
    chk("pix_data", 32'(bus.pix_data), 32'(exp_pix));
    chk("page", 32'(bus.page), 32'(m_page));
    chk("game_rst", 32'(bus.game_rst), 32'((m_page < 2'd2) || !sys_rst_n));
    chk("won", 32'(bus.won), 32'(m_won));
    chk("score_hold", 32'(bus.score_hold), 32'(m_hold));
  endtask

  // One short frame. key_on < 0: key untouched; ev_at < 0: no game event.
  task automatic frame(input int key_on, input int ev_at, input bit ev_over, input bit ev_won);
    int len;
    len = int'($urandom_range(12, 20));
    if (m_page == 2'd0) begin
      bus.game_over = 1'b0;
      bus.game_won  = 1'b0;
    end
    for (int c = 0; c < len; c++) begin
      if (key_on >= 0 && c == key_on) bus.key_any = 1'b1;
      if (key_on >= 0 && c == key_on + 2) bus.key_any = 1'b0;
      if (c == ev_at) begin
        if (ev_over) bus.game_over = 1'b1;
        if (ev_won)  bus.game_won  = 1'b1;
      end
      if (c == len - 1)  step(HL, VL);
      else if (c == 1)   step(HL, 10'($urandom_range(0, 478)));
      else if (c == 2)   step(10'($urandom_range(0, 638)), VL);
      else               step(10'(c), 10'($urandom_range(0, 479)));
    end
  endtask

  task automatic start_game();
    frame(int'($urandom_range(3, 6)), -1, 1'b0, 1'b0);
    chk("enter_arm", 32'(bus.page), 32'd1);
    chk("arm_game_rst", 32'(bus.game_rst), 32'd1);
    frame(-1, -1, 1'b0, 1'b0);
    chk("arm_hold", 32'(bus.page), 32'd1);
    frame(-1, -1, 1'b0, 1'b0);
    chk("enter_play", 32'(bus.page), 32'd2);
    chk("play_game_rst", 32'(bus.game_rst), 32'd0);
  endtask

  initial begin
    int  k, ev;
    bit  eo, ew;
    bus.key_any   = 1'b0;
    bus.game_over = 1'b0;
    bus.game_won  = 1'b0;
    bus.score     = 8'd0;

    // Reset, then three idle frames in START.
    for (int i = 0; i < 3; i++) step(10'd0, 10'd0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) frame(-1, -1, 1'b0, 1'b0);
    chk("idle_page", 32'(bus.page), 32'd0);
    chk("idle_score_hold", 32'(bus.score_hold), 32'd0);

    // Game 1: game_over with score 23, score moves on, early key ignored, late key exits.
    start_game();
    frame(int'($urandom_range(3, 6)), -1, 1'b0, 1'b0);  // key in PLAY does nothing
    bus.score = 8'd23;
    frame(-1, 5, 1'b1, 1'b0);
    chk("end_page", 32'(bus.page), 32'd3);
    chk("end_hold23", 32'(bus.score_hold), 32'd23);
    chk("end_won0", 32'(bus.won), 32'd0);
    bus.score = 8'd24;
    for (int i = 0; i < 100 && m_ticks < 10; i++) frame(-1, -1, 1'b0, 1'b0);
    chk("hold_frozen", 32'(bus.score_hold), 32'd23);
    frame(4, -1, 1'b0, 1'b0);
    chk("early_key_ignored", 32'(bus.page), 32'd3);
    for (int i = 0; i < 100 && m_ticks < 70; i++) frame(-1, -1, 1'b0, 1'b0);
    frame(4, -1, 1'b0, 1'b0);
    chk("late_key_exit", 32'(bus.page), 32'd0);

    // Game 2: over and won together, then auto-return on the 600th END tick.
    start_game();
    bus.score = 8'($urandom);
    frame(-1, 6, 1'b1, 1'b1);
    chk("both_end_page", 32'(bus.page), 32'd3);
    chk("both_won1", 32'(bus.won), 32'd1);
    for (int i = 0; i < END_F - 1; i++) frame(-1, -1, 1'b0, 1'b0);
    chk("end_before_timeout", 32'(bus.page), 32'd3);
    frame(-1, -1, 1'b0, 1'b0);
    chk("end_timeout", 32'(bus.page), 32'd0);

    // Game 3: one-cycle reset in PLAY with the key held through it.
    start_game();
    bus.key_any = 1'b1;
    for (int i = 0; i < 4; i++) step(10'd3, 10'd3);
    sys_rst_n = 1'b0;
    step(10'd4, 10'd4);
    chk("rst_page", 32'(bus.page), 32'd0);
    chk("rst_game_rst", 32'(bus.game_rst), 32'd1);
    chk("rst_pix", 32'(bus.pix_data), 32'd0);
    chk("rst_won", 32'(bus.won), 32'd0);
    chk("rst_hold", 32'(bus.score_hold), 32'd0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) frame(-1, -1, 1'b0, 1'b0);
    chk("held_key_no_start", 32'(bus.page), 32'd0);
    bus.key_any = 1'b0;
    frame(4, -1, 1'b0, 1'b0);
    chk("fresh_key_start", 32'(bus.page), 32'd1);

    // Random play: keys in any page, random end events and scores.
    for (int f = 0; f < 200; f++) begin
      k  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 6)) : -1;
      ev = -1;
      eo = 1'b0;
      ew = 1'b0;
      bus.score = 8'($urandom);
      if (m_page == 2'd2 && $urandom_range(0, 3) == 0) begin
        ev = int'($urandom_range(3, 8));
        eo = 1'($urandom_range(0, 1));
        ew = !eo || ($urandom_range(0, 1) == 1);
      end
      frame(k, ev, eo, ew);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
